// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - MMIO responder: output port, synchronized input port with edge capture, optional timer.
// The timer registers exist only when MMIO_PORT_TIMER_EN is defined.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    localparam logic [2:0] OFF_PORT_OUT = 3'd0;
    localparam logic [2:0] OFF_PORT_IN  = 3'd1;
    localparam logic [2:0] OFF_EDGE_STS = 3'd2;
    localparam logic [2:0] OFF_TMR_CNT  = 3'd3;
    localparam logic [2:0] OFF_TMR_CMP  = 3'd4;
    localparam logic [2:0] OFF_TMR_CTRL = 3'd5;

    logic [2:0]          offset;
    logic                wr_en;
    logic                wr_port_out;
    logic                wr_edge_sts;
    logic                wr_tmr_cnt;
    logic                wr_tmr_cmp;
    logic                wr_tmr_ctrl;

    logic [31:0]         port_out;
    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] prev;
    logic [IN_WIDTH-1:0] rise;
    logic [IN_WIDTH-1:0] edge_sts;
    logic [IN_WIDTH-1:0] edge_clr;
    logic [IN_WIDTH-1:0] edge_next;
    logic [31:0]         port_in_rd;
    logic [31:0]         edge_sts_rd;

    logic [31:0]         tmr_cnt_rd;
    logic [31:0]         tmr_cmp_rd;
    logic [31:0]         tmr_ctrl_rd;
    logic                tmr_irq;

    logic                unused_addr_bits;

    assign unused_addr_bits = ^Address[1:0];

    // Byte lanes are ignored: every register is a full word.
    assign Hit    = (Address[31:5] == BASE_ADDR[31:5]);
    assign offset = Address[4:2];
    assign wr_en  = MemWrite & Hit;

    assign wr_port_out = wr_en && (offset == OFF_PORT_OUT);
    assign wr_edge_sts = wr_en && (offset == OFF_EDGE_STS);
    assign wr_tmr_cnt  = wr_en && (offset == OFF_TMR_CNT);
    assign wr_tmr_cmp  = wr_en && (offset == OFF_TMR_CMP);
    assign wr_tmr_ctrl = wr_en && (offset == OFF_TMR_CTRL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out <= '0;
        end else if (wr_port_out) begin
            port_out <= WriteData;
        end
    end

    assign PortOut = port_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // A rise arriving with a W1C of the same bit keeps the bit set.
    always_comb begin
        edge_clr = '0;
        if (wr_edge_sts) begin
            edge_clr = WriteData[IN_WIDTH-1:0];
        end
        edge_next = (edge_sts & ~edge_clr) | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_sts <= '0;
        end else begin
            edge_sts <= edge_next;
        end
    end

    always_comb begin
        port_in_rd                  = '0;
        port_in_rd[IN_WIDTH-1:0]    = sync2;
        edge_sts_rd                 = '0;
        edge_sts_rd[IN_WIDTH-1:0]   = edge_sts;
    end

`ifdef MMIO_PORT_TIMER_EN
    logic [31:0] tmr_cnt;
    logic [31:0] tmr_cmp;
    logic        tmr_en;
    logic        tmr_autoclr;
    logic        tmr_match;
    logic        match_now;

    assign match_now = tmr_en && (tmr_cnt == tmr_cmp);

    // A software load of the counter beats both the increment and the autoclear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_cnt     <= '0;
            tmr_cmp     <= 32'hFFFF_FFFF;
            tmr_en      <= 1'b0;
            tmr_autoclr <= 1'b0;
            tmr_match   <= 1'b0;
        end else begin
            if (wr_tmr_cnt) begin
                tmr_cnt <= WriteData;
            end else if (tmr_en) begin
                tmr_cnt <= (match_now && tmr_autoclr) ? 32'd0 : tmr_cnt + 32'd1;
            end

            if (wr_tmr_cmp) begin
                tmr_cmp <= WriteData;
            end

            if (wr_tmr_ctrl) begin
                tmr_en      <= WriteData[0];
                tmr_autoclr <= WriteData[1];
            end

            if (match_now) begin
                tmr_match <= 1'b1;
            end else if (wr_tmr_ctrl && WriteData[2]) begin
                tmr_match <= 1'b0;
            end
        end
    end

    assign tmr_cnt_rd  = tmr_cnt;
    assign tmr_cmp_rd  = tmr_cmp;
    assign tmr_ctrl_rd = {29'd0, tmr_match, tmr_autoclr, tmr_en};
    assign tmr_irq     = tmr_match;
`else
    logic unused_tmr_strobes;

    assign unused_tmr_strobes = wr_tmr_cnt ^ wr_tmr_cmp ^ wr_tmr_ctrl;
    assign tmr_cnt_rd  = '0;
    assign tmr_cmp_rd  = '0;
    assign tmr_ctrl_rd = '0;
    assign tmr_irq     = 1'b0;
`endif

    // Loads see the pre-edge register contents, even when a store hits the same word.
    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (offset)
                OFF_PORT_OUT: ReadData = port_out;
                OFF_PORT_IN:  ReadData = port_in_rd;
                OFF_EDGE_STS: ReadData = edge_sts_rd;
                OFF_TMR_CNT:  ReadData = tmr_cnt_rd;
                OFF_TMR_CMP:  ReadData = tmr_cmp_rd;
                OFF_TMR_CTRL: ReadData = tmr_ctrl_rd;
                default:      ReadData = '0;
            endcase
        end
    end

    assign Irq = (|edge_sts) | tmr_irq;

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus, sitting alongside the data RAM.
- Decodes load/store accesses in the MEM stage and services them:
  - a 32-bit output port register;
  - a synchronized 8-bit input port with rising-edge capture;
  - a free-running timer with compare match.
- Produces `Hit` so the top level selects this block's `ReadData` over the RAM's, and gates RAM `MemWrite` when `Hit` is high.

Parameters:
- BASE_ADDR, 32'h1001_0040, base of a 32-byte register window; bits [4:0] must be zero.
- IN_WIDTH, 8, width of `PortIn`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- Address  input  32  byte address from the MEM-stage ALU result
- WriteData  input  32  store data
- MemWrite  input  1  store strobe for this cycle
- MemRead  input  1  load strobe for this cycle
- PortIn  input  IN_WIDTH  asynchronous external inputs
- ReadData  output  32  load data (combinational)
- Hit  output  1  Address falls inside the window (combinational)
- PortOut  output  32  output port register
- Irq  output  1  interrupt request level

Behaviour:
- Decode
  - `Hit` = (Address[31:5] == BASE_ADDR[31:5]).
  - Register offset = Address[4:2]; Address[1:0] are ignored.
  - A write occurs on a rising clk edge when `MemWrite` & `Hit`.
  - `ReadData` = selected register when `MemRead` & `Hit`, else 0. It is combinational, zero latency.
- Register map (offset: name, access)
  - 0x00 PORT_OUT, RW: drives `PortOut` directly.
  - 0x04 PORT_IN, RO: synchronized input, zero-extended.
  - 0x08 EDGE_STS, W1C: bit i sets on a rising edge of synchronized input i.
  - 0x0C TMR_CNT, RW: writes load the counter.
  - 0x10 TMR_CMP, RW: compare value.
  - 0x14 TMR_CTRL, RW: bit0 EN, bit1 AUTOCLR, bit2 MATCH (W1C). Other bits read 0.
  - 0x18, 0x1C: read 0; writes ignored.
- Input path
  - Two-flop synchronizer sync1→sync2, plus a prev flop.
  - rise = sync2 & ~prev.
  - PORT_IN reads sync2, giving 2 cycles latency from a `PortIn` change.
  - An EDGE_STS bit sets the cycle after prev is seen low and sync2 high, i.e. it is visible 3 edges after the `PortIn` rise.
- EDGE_STS update
  - next = (cur & ~(wr ? WriteData : 0)) | rise.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Timer
  - With EN=1, CNT increments by 1 each cycle and wraps 0xFFFF_FFFF→0.
  - When CNT == CMP and EN=1:
    - MATCH sets on the next edge;
    - if AUTOCLR=1, CNT loads 0 instead of CNT+1.
  - A software write to TMR_CNT in the same cycle overrides both the increment and the autoclear.
  - A W1C of MATCH in the same cycle as a new match: set wins.
  - EN=0 freezes CNT; MATCH holds its value.
- Irq = (|EDGE_STS) | MATCH. It is registered-state derived, with no combinational path from the bus.
- Reset (reset low, asynchronous)
  - PORT_OUT, EDGE_STS, CNT, CTRL = 0.
  - CMP = 32'hFFFF_FFFF.
  - Synchronizer and prev flops = 0.
  - `PortOut` = 0, `Irq` = 0.
  - A reset asserted mid-operation clears everything immediately. The first edge capture after release requires the input to be seen low→high post-reset; an input held high through reset produces a rise 2 cycles after release (prev=0). This behaviour is intended.
- `MemRead` and `MemWrite` both high: the write takes effect at the edge; `ReadData` shows the pre-write value.

Optional Feature:
- Macro: MMIO_PORT_TIMER_EN.
- Defined: the timer registers (0x0C–0x14) and MATCH contribution to `Irq` are implemented as above.
- Undefined:
  - no timer flops;
  - offsets 0x0C–0x14 read 0 and writes are ignored;
  - Irq = |EDGE_STS.
- `Hit` decoding is unchanged in both builds.

Test Plan:
- Reset then write PORT_OUT: reset low 3 cycles, release; store 0xA5A5_0F0F to 0x1001_0040 → `PortOut`=0 before the edge and 0xA5A5_0F0F after; load from the same address returns 0xA5A5_0F0F with `Hit`=1; load from 0x1001_0060 → `Hit`=0, `ReadData`=0.
- Input sync and edge capture: PortIn 0x00→0x81 → PORT_IN reads 0x81 two edges later; EDGE_STS=0x81 and `Irq`=1 one edge after that; store 0x01 to 0x1001_0048 → EDGE_STS=0x80, `Irq` stays 1; store 0x80 → `Irq`=0.
- W1C vs. set collision: assert a rise on bit 3 timed to land on the same edge as a store of 0x08 to EDGE_STS → bit 3 reads 1 afterward.
- Timer autoclear: CMP=5, CNT=0, CTRL=0x3 → CNT sequence 1,2,3,4,5,0,1…; MATCH=1 from the edge after CNT=5; storing 0x7 to CTRL clears MATCH while EN and AUTOCLR stay set.
- Timer wrap and write priority: CTRL=0x1, CNT=0xFFFF_FFFE, CMP=0x10 → CNT goes 0xFFFF_FFFF then 0x0; a store of 0x100 to CNT on the cycle CNT==0x10 → CNT=0x100 next, MATCH=1.
- Timer compiled out (MMIO_PORT_TIMER_EN undefined): store 0x3 to 0x1001_0054 then load it → 0, `Hit`=1, `Irq` unaffected.
